// File: rtl/fetch_pc_sequencer.sv
// Program-counter owner and fetch sequencer for the MIPS front end.
// Optional `DELAY_SLOT_EN: honour the branch delay slot instead of flushing.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc4,
    input  logic        redir_jr,
    input  logic [31:0] jr_target,
    input  logic        redir_j,
    input  logic [25:0] j_idx,
    input  logic        redir_br,
    input  logic [15:0] br_imm,
    input  logic [31:0] redir_pc4,
    output logic        flush,
    output logic        addr_err,
    output logic        halted
);

    typedef enum logic [1:0] {BOOT, FETCH, SLOT, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        addr_err_q, addr_err_d;
    logic        active, accept, redir_any, misaligned;
    logic [31:0] pc4, target;

    assign active     = (state_q == FETCH) || (state_q == SLOT);
    assign accept     = active & imem_ack & ~stall;
    assign redir_any  = redir_jr | redir_j | redir_br;
    assign pc4        = pc_q + 32'd4;
    assign misaligned = |target[1:0];

    always_comb begin
        target = redir_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
        if (redir_jr)
            target = jr_target;
        else if (redir_j)
            target = {redir_pc4[31:28], j_idx, 2'b00};
    end

`ifdef DELAY_SLOT_EN
    logic [31:0] tgt_q, tgt_d;

    // Redirect in SLOT is ignored: the delay slot is still outstanding.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        addr_err_d = 1'b0;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (redir_any && misaligned) begin
                    addr_err_d = 1'b1;
                    state_d    = HALTED;
                end else if (redir_any) begin
                    if (accept) begin
                        pc_d = target;
                    end else begin
                        tgt_d   = target;
                        state_d = SLOT;
                    end
                end else if (accept) begin
                    pc_d = pc4;
                end
                if (halt_req) state_d = HALTED;
            end
            SLOT: begin
                if (accept) begin
                    pc_d    = tgt_q;
                    state_d = FETCH;
                end
                if (halt_req) state_d = HALTED;
            end
            default: state_d = HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tgt_q <= 32'd0;
        else        tgt_q <= tgt_d;
    end

    assign flush = 1'b0;
`else
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_err_d = 1'b0;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (redir_any && misaligned) begin
                    addr_err_d = 1'b1;
                    state_d    = HALTED;
                end else if (redir_any) begin
                    pc_d = target;
                end else if (accept) begin
                    pc_d = pc4;
                end
                if (halt_req) state_d = HALTED;
            end
            default: state_d = HALTED;
        endcase
    end

    // The instruction fetched alongside a redirect is on the wrong path.
    assign flush = redir_any & (state_q == FETCH);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign imem_req    = active;
    assign imem_addr   = active ? pc_q : 32'd0;
    assign fetch_valid = accept;
    assign fetch_pc    = active ? pc_q : 32'd0;
    assign fetch_pc4   = active ? pc4 : 32'd0;
    assign addr_err    = addr_err_q;
    assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: reset, sequencing, redirects, stalls, halt.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, stall, halt_req, imem_ack;
    logic        redir_jr, redir_j, redir_br;
    logic [31:0] jr_target, redir_pc4;
    logic [25:0] j_idx;
    logic [15:0] br_imm;
    logic        imem_req, fetch_valid, flush, addr_err, halted;
    logic [31:0] imem_addr, fetch_pc, fetch_pc4;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_pc_sequencer #(.RESET_VECTOR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pc4(fetch_pc4),
        .redir_jr(redir_jr), .jr_target(jr_target), .redir_j(redir_j),
        .j_idx(j_idx), .redir_br(redir_br), .br_imm(br_imm),
        .redir_pc4(redir_pc4), .flush(flush), .addr_err(addr_err),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redir();
        redir_jr = 1'b0; redir_j = 1'b0; redir_br = 1'b0;
    endtask

    // Reset, then land in FETCH at RESET_VECTOR.
    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; halt_req = 1'b0; imem_ack = 1'b1;
        clear_redir();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; halt_req = 1'b0; imem_ack = 1'b1;
        clear_redir();
        jr_target = 32'h0; redir_pc4 = 32'h0; j_idx = 26'h0; br_imm = 16'h0;
        repeat (2) tick();
        n_tests++;
        if ({imem_req, fetch_valid, flush, addr_err, halted} !== 5'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: req/vld/flush/err/halt=%b addr=%h, need 00000 and 0",
                     {imem_req, fetch_valid, flush, addr_err, halted}, imem_addr);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL boot_no_req: imem_req=%b need 0", imem_req);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4) || fetch_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_addr%0d: req=%b addr=%h vld=%b need 1 %h 1",
                         i, imem_req, imem_addr, fetch_valid, 32'(i * 4));
            end
            tick();
        end
    endtask

    task automatic test_jump();
        logic exp_flush;
`ifdef DELAY_SLOT_EN
        exp_flush = 1'b0;
`else
        exp_flush = 1'b1;
`endif
        redir_j = 1'b1; redir_pc4 = 32'h1000_0008; j_idx = 26'h100;
        #1;
        n_tests++;
        if (flush !== exp_flush) begin
            n_fail++; $display("FAIL jump_flush: flush=%b need %b", flush, exp_flush);
        end
        tick();
        clear_redir();
        #1;
        n_tests++;
        if (imem_addr !== 32'h1000_0400 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_target: addr=%h flush=%b need 10000400 0", imem_addr, flush);
        end
    endtask

    task automatic test_branch();
        redir_br = 1'b1; redir_pc4 = 32'h20; br_imm = 16'hFFFE;
        tick();
        clear_redir();
        n_tests++;
        if (imem_addr !== 32'h18) begin
            n_fail++; $display("FAIL branch_back: addr=%h need 00000018", imem_addr);
        end
        redir_br = 1'b1; redir_jr = 1'b1; jr_target = 32'h200;
        tick();
        clear_redir();
        n_tests++;
        if (imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL jr_over_br: addr=%h need 00000200", imem_addr);
        end
        redir_br = 1'b1; redir_j = 1'b1; redir_pc4 = 32'h20; j_idx = 26'h10;
        tick();
        clear_redir();
        n_tests++;
        if (imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL j_over_br: addr=%h need 00000040", imem_addr);
        end
`ifndef DELAY_SLOT_EN
        imem_ack = 1'b0; redir_jr = 1'b1; jr_target = 32'h80;
        tick();
        clear_redir();
        imem_ack = 1'b1;
        n_tests++;
        if (imem_addr !== 32'h80) begin
            n_fail++; $display("FAIL redir_no_ack: addr=%h need 00000080", imem_addr);
        end
`endif
    endtask

    task automatic test_stall_wrap();
        redir_jr = 1'b1; jr_target = 32'hFFFF_FFFC;
        tick();
        clear_redir();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1 || fetch_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: addr=%h req=%b vld=%b need fffffffc 1 0",
                         i, imem_addr, imem_req, fetch_valid);
            end
            tick();
        end
        stall = 1'b0;
        #1;
        n_tests++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'hFFFF_FFFC || fetch_pc4 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_accept: vld=%b pc=%h pc4=%h need 1 fffffffc 00000000",
                     fetch_valid, fetch_pc, fetch_pc4);
        end
        tick();
        n_tests++;
        if (imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addr: addr=%h need 00000000", imem_addr);
        end
        imem_ack = 1'b0;
        tick();
        n_tests++;
        if (imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin
            n_fail++; $display("FAIL noack_hold: addr=%h vld=%b need 0 0", imem_addr, fetch_valid);
        end
        imem_ack = 1'b1;
        tick();
        n_tests++;
        if (imem_addr !== 32'h4) begin
            n_fail++; $display("FAIL ack_resume: addr=%h need 00000004", imem_addr);
        end
    endtask

    task automatic test_halt_req();
        halt_req = 1'b1;
        #1;
        n_tests++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'h4) begin
            n_fail++; $display("FAIL halt_last_accept: vld=%b pc=%h need 1 4", fetch_valid, fetch_pc);
        end
        tick();
        halt_req = 1'b0;
        n_tests++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_state: halted=%b req=%b vld=%b need 1 0 0", halted, imem_req, fetch_valid);
        end
    endtask

    task automatic test_reset_midop();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (halted !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: halted=%b req=%b need 0 0", halted, imem_req);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_restart: req=%b addr=%h need 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_misaligned();
        redir_jr = 1'b1; jr_target = 32'h102;
        tick();
        clear_redir();
        n_tests++;
        if (addr_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_err: err=%b halted=%b req=%b need 1 1 0", addr_err, halted, imem_req);
        end
        redir_j = 1'b1; redir_pc4 = 32'h0; j_idx = 26'h4;
        tick();
        clear_redir();
        n_tests++;
        if (addr_err !== 1'b0 || halted !== 1'b1) begin
            n_fail++; $display("FAIL misalign_pulse: err=%b halted=%b need 0 1", addr_err, halted);
        end
        tick();
        n_tests++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halted_sticky: halted=%b req=%b vld=%b need 1 0 0", halted, imem_req, fetch_valid);
        end
    endtask

`ifdef DELAY_SLOT_EN
    task automatic test_delay_slot();
        do_reset();
        redir_jr = 1'b1; jr_target = 32'h40;
        tick();
        imem_ack = 1'b0; jr_target = 32'h100;
        #1;
        n_tests++;
        if (flush !== 1'b0) begin
            n_fail++; $display("FAIL ds_flush: flush=%b need 0", flush);
        end
        tick();
        clear_redir();
        n_tests++;
        if (imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL ds_slot_addr: addr=%h need 00000040", imem_addr);
        end
        imem_ack = 1'b1;
        #1;
        n_tests++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'h40) begin
            n_fail++; $display("FAIL ds_slot_accept: vld=%b pc=%h need 1 40", fetch_valid, fetch_pc);
        end
        tick();
        n_tests++;
        if (imem_addr !== 32'h100 || flush !== 1'b0) begin
            n_fail++; $display("FAIL ds_target: addr=%h flush=%b need 00000100 0", imem_addr, flush);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_jump();
        test_branch();
        test_stall_wrap();
        test_halt_req();
        test_reset_midop();
        test_misaligned();
`ifdef DELAY_SLOT_EN
        test_delay_slot();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
